// File: rtl/user_entry_if.sv
// rtl/user_entry_if.sv - switch/button entry bus between the board inputs and the guess assembler
interface user_entry_if;
  logic        enable;
  logic [3:0]  sw;
  logic        btn_digit;
  logic        btn_back;
  logic        btn_clear;
  logic        btn_enter;
  logic [15:0] userInt;
  logic [2:0]  digit_count;
  logic        submit;
  logic        busy;

  modport master (
    output enable, sw, btn_digit, btn_back, btn_clear, btn_enter,
    input  userInt, digit_count, submit, busy
  );

  modport slave (
    input  enable, sw, btn_digit, btn_back, btn_clear, btn_enter,
    output userInt, digit_count, submit, busy
  );
endinterface

// File: rtl/user_entry.sv
// rtl/user_entry.sv - debounced four-button hex guess entry with IDLE/ENTRY/DONE sequencing
module user_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input logic        clk,
  input logic        rst,
  user_entry_if.slave ue
);
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

  // button bit order: [0]=digit [1]=back [2]=clear [3]=enter
  logic [3:0]  btn_raw, sync1, sync2, deb, deb_q, press;
  logic [15:0] db_cnt [4];

  state_t      state, state_n;
  logic [15:0] value, value_n;
  logic [2:0]  count, count_n;
  logic        submit, submit_n;

  assign btn_raw = {ue.btn_enter, ue.btn_clear, ue.btn_back, ue.btn_digit};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      // deb flips only after sync2 has disagreed for DEBOUNCE_CYCLES straight cycles
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      value  <= '0;
      count  <= '0;
      submit <= 1'b0;
    end else begin
      state  <= state_n;
      value  <= value_n;
      count  <= count_n;
      submit <= submit_n;
    end
  end

  always_comb begin
    state_n  = state;
    value_n  = value;
    count_n  = count;
    submit_n = 1'b0;
    case (state)
      IDLE: begin
        if (ue.enable) begin
          state_n = ENTRY;
          value_n = '0;
          count_n = '0;
        end
      end
      ENTRY: begin
        if (!ue.enable) begin
          state_n = IDLE;
          value_n = '0;
          count_n = '0;
        end else if (press[2]) begin
          value_n = '0;
          count_n = '0;
        end else if (press[1]) begin
          if (count != 3'd0) begin
            value_n = {4'h0, value[15:4]};
            count_n = count - 3'd1;
          end
        end else if (press[0]) begin
          if (count != 3'd4) begin
            value_n = {value[11:0], ue.sw};
            count_n = count + 3'd1;
          end
        end else if (press[3]) begin
          if (count == 3'd4) begin
            submit_n = 1'b1;
            state_n  = DONE;
          end
        end
      end
      DONE: begin
        if (!ue.enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign ue.userInt     = value;
  assign ue.digit_count = count;
  assign ue.submit      = submit;
  assign ue.busy        = (state == ENTRY);
endmodule

// File: doc/user_entry.md
USER_ENTRY -- requirements
Module: user_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive clk cycles a synchronized button level must hold before it is accepted; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 enable  input  1  entry window open, driven by the game controller.
REQ-005 sw  input  4  hex digit value presented by the switches.
REQ-006 btn_digit  input  1  raw button: append sw as the next digit.
REQ-007 btn_back  input  1  raw button: delete the last digit.
REQ-008 btn_clear  input  1  raw button: discard all digits.
REQ-009 btn_enter  input  1  raw button: submit the entry.
REQ-010 userInt  output  16  assembled guess, first-entered digit in [15:12]; feeds checkInput.userInt.
REQ-011 digit_count  output  3  number of digits entered, 0..4.
REQ-012 submit  output  1  one-cycle pulse; userInt is valid for checking while submit is high and afterwards.
REQ-013 busy  output  1  high in state ENTRY.

Function
REQ-014 Each btn_* input shall pass through a 2-flop synchronizer and then an independent debounce counter; the debounced level shall change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 Each button shall produce a one-cycle press event on the rising edge of its debounced level; releases, and holds longer than one cycle, shall produce no further events.
REQ-016 State machine states: IDLE, ENTRY, DONE.
REQ-017 IDLE: busy=0 and press events are ignored; when enable=1 go to ENTRY next cycle with userInt=0 and digit_count=0.
REQ-018 ENTRY: a digit event with digit_count<4 sets userInt<={userInt[11:0],sw} and increments digit_count; with digit_count=4 it is ignored.
REQ-019 ENTRY: a back event with digit_count>0 sets userInt<={4'h0,userInt[15:4]} and decrements digit_count; with digit_count=0 it is ignored.
REQ-020 ENTRY: a clear event sets userInt=0 and digit_count=0.
REQ-021 ENTRY: an enter event with digit_count=4 asserts submit for exactly one cycle and goes to DONE; with digit_count<4 it is ignored.
REQ-022 If several events arrive in the same cycle, only the highest-priority one shall act: clear > back > digit > enter.
REQ-023 Register updates caused by an event shall be visible on the cycle after the event; submit shall be high in the same cycle that digit_count=4 is first observable in DONE.
REQ-024 DONE: userInt and digit_count shall hold; all events are ignored; when enable=0 go to IDLE.
REQ-025 enable=0 in ENTRY shall go to IDLE next cycle with userInt and digit_count cleared and no submit.
REQ-026 sw shall be sampled only in the cycle the digit event occurs; sw changes at any other time have no effect.
REQ-027 submit shall never assert twice without an intervening pass through IDLE.

Reset
REQ-028 While rst=0: state=IDLE, userInt=16'h0000, digit_count=0, submit=0, busy=0, all synchronizer, debounce and edge registers cleared to released.
REQ-029 A button already held when rst rises shall generate a press event only after its debounce interval completes.
REQ-030 rst=0 mid-entry or in DONE shall abort the entry in the same clock edge, with no submit.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 enable=1; press digit with sw=1,2,3,4 in turn, then enter -> userInt=16'h1234, digit_count=4, exactly one submit pulse, state DONE.
REQ-032 Enter digits A,B, then back, then C -> userInt=16'h00AC, digit_count=2; enter -> no submit.
REQ-033 Glitch btn_digit high for 3 cycles -> no change; hold it for 10 cycles -> exactly one digit appended.
REQ-034 Digit and clear events in the same cycle -> userInt=0, digit_count=0; a fifth digit after 4 digits -> userInt is unchanged.
REQ-035 In DONE, press digit, back and enter -> no change and no submit; drop enable -> IDLE; raise enable again -> userInt=0.
REQ-036 Assert rst=0 after 3 digits -> all outputs are at reset values on the next cycle; a button held across reset generates exactly one event after debounce.
